// File: rtl/dez_min_countdown.sv
// ============================================================================
// dez_min_countdown : BCD tens-of-minutes down-counter with valve-control FSM.
// Optional macro DEZ_MIN_AUTO_RELOAD_EN enables cyclic reload after DONE.
// Revision 1.0
// ============================================================================
`default_nettype none

module dez_min_countdown #(
  parameter int WIDTH    = 4,
  parameter int MAX_TENS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_tens,
  input  logic             start,
  input  logic             pause,
  input  logic             borrow_in,
  input  logic             units_zero,
  output logic [WIDTH-1:0] tens,
  output logic             valve_on,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_TENS_V = WIDTH'(MAX_TENS);
  localparam logic [WIDTH-1:0] ONE_V      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tens_q, tens_d;
  logic             borrow_q;
  logic             valve_on_q, done_q, busy_q;

  logic [WIDTH-1:0] load_sat;
  logic             borrow_edge;
  logic             count_zero;

  assign load_sat    = (load_tens > MAX_TENS_V) ? MAX_TENS_V : load_tens;
  assign borrow_edge = borrow_in & ~borrow_q;
  assign count_zero  = (tens_q == '0) && units_zero;

`ifdef DEZ_MIN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  always_comb begin
    reload_d = reload_q;
    if (load) reload_d = load_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else        reload_q <= reload_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    if (load) begin
      tens_d  = load_sat;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = count_zero ? S_DONE : S_RUN;
        end
        S_RUN: begin
          // Pause wins over a coincident borrow edge; that edge is lost.
          if (count_zero)                         state_d = S_DONE;
          else if (pause)                         state_d = S_PAUSE;
          else if (borrow_edge && tens_q != '0)   tens_d  = tens_q - ONE_V;
        end
        S_PAUSE: begin
          if (!pause) state_d = S_RUN;
        end
        S_DONE: begin
`ifdef DEZ_MIN_AUTO_RELOAD_EN
          tens_d  = reload_q;
          state_d = S_RUN;
`else
          state_d = S_DONE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tens_q     <= '0;
      borrow_q   <= 1'b1;
      valve_on_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      borrow_q   <= borrow_in;
      valve_on_q <= (state_d == S_RUN);
      done_q     <= (state_d == S_DONE);
      busy_q     <= (state_d == S_RUN) || (state_d == S_PAUSE);
    end
  end

  assign tens     = tens_q;
  assign valve_on = valve_on_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dez_min_countdown.sv
// ============================================================================
// tb_dez_min_countdown : directed self-checking bench for dez_min_countdown.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dez_min_countdown;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       borrow_in = 1'b1;
  logic       units_zero = 1'b0;
  logic [3:0] tens;
  logic       valve_on;
  logic       done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  dez_min_countdown #(.WIDTH(4), .MAX_TENS(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_tens  (load_tens),
    .start      (start),
    .pause      (pause),
    .borrow_in  (borrow_in),
    .units_zero (units_zero),
    .tens       (tens),
    .valve_on   (valve_on),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_borrow();
    borrow_in = 1'b0;
    tick();
    borrow_in = 1'b1;
    tick();
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_tens = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset asserted with pending inputs: outputs clear without a clock edge.
    load = 1'b1; load_tens = 4'd3; start = 1'b1; borrow_in = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_tens", tens, 0);
    check("rst_valve", valve_on, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    tick(); tick();
    check("rst_hold_tens", tens, 0);
    load = 1'b0; start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // Basic run 3 -> 0, then DONE.
    do_load(4'd3);
    check("load3_tens", tens, 3);
    check("load3_busy", busy, 0);
    do_start();
    check("run_valve", valve_on, 1);
    check("run_busy", busy, 1);
    tick();
    check("hi_borrow_no_dec", tens, 3);
    pulse_borrow();
    check("dec_to_2", tens, 2);
    check("run_valve_2", valve_on, 1);
    pulse_borrow();
    check("dec_to_1", tens, 1);
    pulse_borrow();
    check("dec_to_0", tens, 0);
    check("valve_at_0", valve_on, 1);
    check("done_not_yet", done, 0);
    units_zero = 1'b1;
    tick();
    check("done_set", done, 1);
    check("done_valve_off", valve_on, 0);
    check("done_busy", busy, 0);
    tick();
`ifdef DEZ_MIN_AUTO_RELOAD_EN
    check("reload_done_pulse", done, 0);
    check("reload_tens", tens, 3);
    check("reload_valve", valve_on, 1);
`else
    check("done_hold", done, 1);
    check("done_hold_valve", valve_on, 0);
`endif
    units_zero = 1'b0;

    // Saturating load; load aborts a run and beats start.
    do_load(4'd9);
    check("sat_tens", tens, 5);
    check("sat_done_clr", done, 0);
    check("sat_busy", busy, 0);
    do_start();
    check("sat_run_valve", valve_on, 1);
    load = 1'b1; start = 1'b1; load_tens = 4'd4;
    tick();
    load = 1'b0; start = 1'b0;
    check("ld_start_valve", valve_on, 0);
    check("ld_start_busy", busy, 0);
    check("ld_start_tens", tens, 4);
    tick();
    check("ld_start_idle", busy, 0);

    // Pause drops edges and closes the valve.
    do_start();
    check("p_run_valve", valve_on, 1);
    pause = 1'b1;
    tick();
    check("p_valve_off", valve_on, 0);
    check("p_busy", busy, 1);
    pulse_borrow();
    pulse_borrow();
    check("p_tens_hold", tens, 4);
    pause = 1'b0;
    tick();
    check("p_resume_valve", valve_on, 1);
    pulse_borrow();
    check("p_resume_dec", tens, 3);

    // No wrap below zero; DONE beats pause.
    do_load(4'd0);
    do_start();
    check("z_run_valve", valve_on, 1);
    pulse_borrow();
    check("z_no_wrap", tens, 0);
    check("z_not_done", done, 0);
    units_zero = 1'b1; pause = 1'b1;
    tick();
    check("z_done", done, 1);
    check("z_done_valve", valve_on, 0);
    pause = 1'b0;
    tick();
`ifdef DEZ_MIN_AUTO_RELOAD_EN
    check("z_reload_run", done, 0);
    check("z_reload_valve", valve_on, 1);
    tick();
    check("z_reload_redone", done, 1);
`else
    check("z_done_hold", done, 1);
`endif

    // IDLE start with zero count goes straight to DONE.
    do_load(4'd0);
    check("i_done_clr", done, 0);
    do_start();
    check("i_done", done, 1);
    check("i_valve", valve_on, 0);
    units_zero = 1'b0;

    // Reset mid-run closes the valve immediately.
    do_load(4'd3);
    do_start();
    check("mr_valve", valve_on, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valve_off", valve_on, 0);
    check("mr_tens", tens, 0);
    check("mr_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
